// File: rtl/usb_phy_tx.sv
// usb_phy_tx -- USB full-speed transmit line encoder.
//
// Turns a stream of packet bytes into driven USB line states: SYNC
// (NRZI of 0x80), NRZI-encoded data sent LSB first with bit stuffing after
// six consecutive ones, then an SE0,SE0,J end-of-packet.  Each line bit is
// held for CLK_DIV clock cycles.
//
// Parameters:
//   CLK_DIV   clock cycles per line bit time (2..16); 4 gives 12 Mb/s from 48 MHz
//
// Ports:
//   clk       single clock, all flops on its rising edge
//   rst       synchronous active-high reset; aborts a packet with no EOP
//   tx_data   packet byte, sent LSB first
//   tx_valid  byte available; starts a packet in IDLE, ends it when low
//             at a byte request
//   tx_ready  one-cycle pulse at a byte request; tx_data taken if tx_valid
//   tx_line   driven line state: SE0=00, J=01, K=10
//   tx_oe     line driver enable
//   tx_busy   high from the first SYNC bit to the end of the EOP J bit
//   tx_abort  (only with USB_PHY_TX_ABORT_EN) force a stuff error, then EOP
//
// Optional feature: define USB_PHY_TX_ABORT_EN to add tx_abort and the
// abort sequence (7 bit times without transitions followed by EOP).

module usb_phy_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
`ifdef USB_PHY_TX_ABORT_EN
  input  logic       tx_abort,
`endif
  output logic       tx_ready,
  output logic [1:0] tx_line,
  output logic       tx_oe,
  output logic       tx_busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_EOP  = 2'd3;

  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_J   = 2'b01;
  localparam logic [1:0] LINE_K   = 2'b10;

  localparam logic [2:0] USB_STUFF_BITS_N = 3'd6;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       ones_q, ones_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       line_q, line_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
`ifdef USB_PHY_TX_ABORT_EN
  logic             abort_pend_q, abort_pend_d;
  logic             abort_act_q, abort_act_d;
`endif

  logic strobe;
  logic send_en;
  logic send_val;

  function automatic logic [1:0] nrzi_toggle(input logic [1:0] s);
    return (s == LINE_J) ? LINE_K : LINE_J;
  endfunction

  // bit_cnt_q indexes the bit currently on the line (SYNC/DATA), the EOP
  // bit, or the hold bit during an abort.  shift_q[0] is always the bit
  // currently on the line, so the next one is shift_q[1].  A stuffed bit
  // does not advance bit_cnt_q or shift_q, which is what makes the byte
  // request slip by one bit time.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    shift_d   = shift_q;
    line_d    = line_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    tx_ready  = 1'b0;
    send_en   = 1'b0;
    send_val  = 1'b0;
`ifdef USB_PHY_TX_ABORT_EN
    abort_pend_d = abort_pend_q;
    abort_act_d  = abort_act_q;
`endif
    strobe = (state_q != ST_IDLE) && (div_q == DIV_LAST);

    case (state_q)
      ST_IDLE: begin
        div_d     = '0;
        bit_cnt_d = 3'd0;
        ones_d    = 3'd0;
        line_d    = LINE_J;
        oe_d      = 1'b0;
        busy_d    = 1'b0;
`ifdef USB_PHY_TX_ABORT_EN
        abort_pend_d = 1'b0;
        abort_act_d  = 1'b0;
`endif
        if (tx_valid) begin
          // First SYNC bit is a 0, so J toggles to K right away.
          state_d = ST_SYNC;
          shift_d = 8'h80;
          line_d  = LINE_K;
          oe_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_SYNC, ST_DATA: begin
        div_d = strobe ? '0 : div_q + DIV_W'(1);
`ifdef USB_PHY_TX_ABORT_EN
        if (!strobe && tx_abort && !abort_act_q) begin
          abort_pend_d = 1'b1;
        end
        if (strobe && abort_act_q) begin
          // Line is held for 7 bit slots, then EOP starts.
          if (bit_cnt_q == 3'd6) begin
            state_d     = ST_EOP;
            line_d      = LINE_SE0;
            bit_cnt_d   = 3'd0;
            abort_act_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (strobe && (abort_pend_q || tx_abort)) begin
          state_d      = ST_DATA;
          abort_pend_d = 1'b0;
          abort_act_d  = 1'b1;
          bit_cnt_d    = 3'd0;
        end else if (strobe) begin
`else
        if (strobe) begin
`endif
          if (ones_q == USB_STUFF_BITS_N) begin
            line_d = nrzi_toggle(line_q);
            ones_d = 3'd0;
          end else if (bit_cnt_q == 3'd7) begin
            tx_ready = 1'b1;
            if (tx_valid) begin
              state_d   = ST_DATA;
              shift_d   = tx_data;
              bit_cnt_d = 3'd0;
              send_en   = 1'b1;
              send_val  = tx_data[0];
            end else begin
              state_d   = ST_EOP;
              line_d    = LINE_SE0;
              bit_cnt_d = 3'd0;
              ones_d    = 3'd0;
            end
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            send_en   = 1'b1;
            send_val  = shift_q[1];
          end
        end
      end

      ST_EOP: begin
        div_d = strobe ? '0 : div_q + DIV_W'(1);
        if (strobe) begin
          if (bit_cnt_q == 3'd2) begin
            state_d   = ST_IDLE;
            div_d     = '0;
            bit_cnt_d = 3'd0;
            line_d    = LINE_J;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            line_d    = (bit_cnt_q == 3'd1) ? LINE_J : LINE_SE0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // NRZI: a 0 toggles J<->K, a 1 holds the line and extends the ones run.
    if (send_en) begin
      line_d = send_val ? line_q : nrzi_toggle(line_q);
      ones_d = send_val ? ones_q + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_cnt_q <= 3'd0;
      ones_q    <= 3'd0;
      shift_q   <= 8'h00;
      line_q    <= LINE_J;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef USB_PHY_TX_ABORT_EN
      abort_pend_q <= 1'b0;
      abort_act_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      shift_q   <= shift_d;
      line_q    <= line_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
`ifdef USB_PHY_TX_ABORT_EN
      abort_pend_q <= abort_pend_d;
      abort_act_q  <= abort_act_d;
`endif
    end
  end

  assign tx_line = line_q;
  assign tx_oe   = oe_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_usb_phy_tx.sv
// tb_usb_phy_tx -- self-checking bench for usb_phy_tx.
//
// A reference model builds, per packet, the list of line states one entry
// per bit slot (SYNC, NRZI data with stuffing, EOP) and marks which slots
// end with a byte request.  The bench then steps the DUT cycle by cycle
// and compares every output against that list.

module tb_usb_phy_tx;

   localparam int DIV = 4;

   localparam logic [1:0] LSE0 = 2'b00;
   localparam logic [1:0] LJ   = 2'b01;
   localparam logic [1:0] LK   = 2'b10;

   logic       clk;
   logic       rst;
   logic [7:0] txData;
   logic       txValid;
   logic       txReady;
   logic [1:0] txLine;
   logic       txOe;
   logic       txBusy;
`ifdef USB_PHY_TX_ABORT_EN
   logic       txAbort;
`endif

   int checks;
   int errors;

   logic [7:0] pktBytes[$];
   logic [1:0] expSlot[$];
   bit         expReq[$];
   logic [1:0] obsSlot[$];
   int         readyAll[$];
   int         readyUsed[$];
   int         oeCount;

   logic [1:0] a5Table[19] = '{LK, LJ, LK, LJ, LK, LJ, LK, LK,
                               LK, LJ, LJ, LK, LJ, LJ, LK, LK,
                               LSE0, LSE0, LJ};
   logic [1:0] ffTable[9]  = '{LK, LK, LK, LK, LK, LJ, LJ, LJ, LJ};

   usb_phy_tx #(.CLK_DIV(DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (txData),
      .tx_valid (txValid),
`ifdef USB_PHY_TX_ABORT_EN
      .tx_abort (txAbort),
`endif
      .tx_ready (txReady),
      .tx_line  (txLine),
      .tx_oe    (txOe),
      .tx_busy  (txBusy)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net in case the DUT or bench stalls.
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [1:0] flip(input logic [1:0] s);
      return (s == LJ) ? LK : LJ;
   endfunction

   function automatic logic [7:0] pickByte();
      case ($urandom_range(0, 5))
         0:       return 8'hFF;
         1:       return 8'h00;
         2:       return 8'hFC;
         3:       return 8'h7E;
         default: return 8'($urandom);
      endcase
   endfunction

   // Reference model: line state per bit slot from the protocol rules.
   function automatic void buildModel(input int abortSlot);
      logic [1:0] cur;
      logic [1:0] keep;
      int         run;
      logic       b;
      expSlot.delete();
      expReq.delete();
      cur = LJ;
      run = 0;
      for (int i = 0; i < 8; i++) begin
         b   = (i == 7);
         cur = b ? cur : flip(cur);
         run = b ? run + 1 : 0;
         expSlot.push_back(cur);
         expReq.push_back(i == 7);
      end
      foreach (pktBytes[k]) begin
         for (int i = 0; i < 8; i++) begin
            b   = pktBytes[k][i];
            cur = b ? cur : flip(cur);
            run = b ? run + 1 : 0;
            expSlot.push_back(cur);
            expReq.push_back(1'b0);
            if (run == 6) begin
               cur = flip(cur);
               run = 0;
               expSlot.push_back(cur);
               expReq.push_back(1'b0);
            end
         end
         expReq[expReq.size() - 1] = 1'b1;
      end
      if (abortSlot >= 0) begin
         keep = expSlot[abortSlot];
         while (expSlot.size() > abortSlot + 1) begin
            void'(expSlot.pop_back());
            void'(expReq.pop_back());
         end
         expReq[abortSlot] = 1'b0;
         repeat (7) begin
            expSlot.push_back(keep);
            expReq.push_back(1'b0);
         end
      end
      expSlot.push_back(LSE0); expReq.push_back(1'b0);
      expSlot.push_back(LSE0); expReq.push_back(1'b0);
      expSlot.push_back(LJ);   expReq.push_back(1'b0);
   endfunction

   // Sends pktBytes as one packet and checks every cycle of it, plus the
   // first IDLE cycle afterwards.  Entered and left just before a posedge.
   task automatic applyStimulus(input int abortSlot);
      int   nCyc;
      int   eopCyc;
      int   byteIdx;
      int   s;
      logic expRdy;
`ifdef USB_PHY_TX_ABORT_EN
      int   abortCyc;
      abortCyc = (abortSlot >= 0) ? abortSlot * DIV + 1 : -1;
`endif
      buildModel(abortSlot);
      nCyc   = expSlot.size() * DIV;
      eopCyc = (expSlot.size() - 3) * DIV;
      obsSlot.delete();
      readyAll.delete();
      readyUsed.delete();
      oeCount = 0;
      byteIdx = 0;
      expRdy  = 1'b0;
      txValid = 1'b1;
      txData  = pktBytes[0];
      @(posedge clk);
      for (int c = 0; c <= nCyc; c++) begin
         @(negedge clk);
         if (c < nCyc) begin
            s      = c / DIV;
            expRdy = expReq[s] && (c % DIV == DIV - 1);
            if (c % DIV == 0) obsSlot.push_back(txLine);
            if (txOe) oeCount++;
            if (txReady) readyAll.push_back(c);
            if (txReady && txValid) readyUsed.push_back(c);
            checkOutput("line", 32'(txLine), 32'(expSlot[s]));
            checkOutput("oe", 32'(txOe), 32'd1);
            checkOutput("busy", 32'(txBusy), 32'd1);
            checkOutput("ready", 32'(txReady), 32'(expRdy));
         end else begin
            checkOutput("idleLine", 32'(txLine), 32'(LJ));
            checkOutput("idleOe", 32'(txOe), 32'd0);
            checkOutput("idleBusy", 32'(txBusy), 32'd0);
            checkOutput("idleReady", 32'(txReady), 32'd0);
         end
         if (c < nCyc) begin
            @(posedge clk);
            #1;
            if (expRdy) begin
               byteIdx++;
               if (byteIdx < pktBytes.size()) begin
                  txData = pktBytes[byteIdx];
               end else begin
                  txValid = 1'b0;
                  txData  = 8'($urandom);
               end
            end
            if (c + 1 >= eopCyc && c + 1 < nCyc) txValid = 1'($urandom_range(0, 1));
            if (c + 1 == nCyc) txValid = 1'b0;
`ifdef USB_PHY_TX_ABORT_EN
            txAbort = (c + 1 == abortCyc);
`endif
         end
      end
   endtask

   // Main sequence: reset, directed packets, random packets, mid-packet reset.
   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      txValid = 1'b0;
      txData  = 8'h00;
`ifdef USB_PHY_TX_ABORT_EN
      txAbort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstLine", 32'(txLine), 32'(LJ));
      checkOutput("rstOe", 32'(txOe), 32'd0);
      checkOutput("rstBusy", 32'(txBusy), 32'd0);
      checkOutput("rstReady", 32'(txReady), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);

      pktBytes = '{8'hA5};
      applyStimulus(-1);
      for (int i = 0; i < 19; i++) checkOutput("a5Bit", 32'(obsSlot[i]), 32'(a5Table[i]));
      checkOutput("a5OeLen", 32'(oeCount), 32'd76);
      checkOutput("a5Used", 32'(readyUsed.size()), 32'd1);

      pktBytes = '{8'hFF};
      applyStimulus(-1);
      for (int i = 0; i < 9; i++) checkOutput("ffBit", 32'(obsSlot[8 + i]), 32'(ffTable[i]));
      checkOutput("ffGap", 32'(readyAll[1] - readyAll[0]), 32'd36);

      pktBytes = '{8'h00, 8'hFC};
      applyStimulus(-1);
      checkOutput("fcLast", 32'(obsSlot[23]), 32'(LK));
      checkOutput("fcStuff", 32'(obsSlot[24]), 32'(LJ));
      checkOutput("fcSe0", 32'(obsSlot[25]), 32'(LSE0));

      pktBytes = '{8'h12, 8'h34, 8'h56};
      applyStimulus(-1);
      checkOutput("b2bCount", 32'(readyUsed.size()), 32'd3);
      checkOutput("b2bGap1", 32'(readyUsed[1] - readyUsed[0]), 32'd32);
      checkOutput("b2bGap2", 32'(readyUsed[2] - readyUsed[1]), 32'd32);

      for (int p = 0; p < 30; p++) begin
         pktBytes.delete();
         repeat ($urandom_range(1, 4)) pktBytes.push_back(pickByte());
         applyStimulus(-1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

`ifdef USB_PHY_TX_ABORT_EN
      for (int p = 0; p < 4; p++) begin
         pktBytes.delete();
         repeat (2) pktBytes.push_back(pickByte());
         applyStimulus(8 + $urandom_range(0, 7));
         checkOutput("abortOeLen", 32'(oeCount), 32'(expSlot.size() * DIV));
      end
`endif

      // Reset during the third data bit (slot 10) aborts without EOP.
      txValid = 1'b1;
      txData  = 8'h5A;
      @(posedge clk);
      repeat (41) @(posedge clk);
      #1;
      rst     = 1'b1;
      txValid = 1'b0;
      @(negedge clk);
      checkOutput("preRstOe", 32'(txOe), 32'd1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("midRstOe", 32'(txOe), 32'd0);
      checkOutput("midRstLine", 32'(txLine), 32'(LJ));
      checkOutput("midRstBusy", 32'(txBusy), 32'd0);
      checkOutput("midRstReady", 32'(txReady), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checkOutput("postRstLine", 32'(txLine), 32'(LJ));
         checkOutput("postRstOe", 32'(txOe), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/usb_phy_tx.md
USB_PHY_TX -- requirements
Module: usb_phy_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clock cycles per line bit time (48 MHz clock -> 12 Mb/s full speed); legal range 2..16.
REQ-002 SHALL have port clk  input  1  single clock; every flop in the block runs on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port tx_data  input  8  packet byte, sent LSB first.
REQ-005 SHALL have port tx_valid  input  1  byte available; high in IDLE starts a packet; low at a byte request ends it.
REQ-006 SHALL have port tx_ready  output  1  one-cycle pulse; tx_data is consumed in that cycle if tx_valid is high.
REQ-007 SHALL have port tx_line  output  2  driven line state, usb_line_state_t encoding (SE0=00, J=01, K=10; SE1 never driven).
REQ-008 SHALL have port tx_oe  output  1  line driver enable.
REQ-009 SHALL have port tx_busy  output  1  high from the first SYNC bit to the end of the EOP J bit.

Function
REQ-010 SHALL implement FSM states IDLE, SYNC, DATA, EOP; transitions: IDLE->SYNC on tx_valid; SYNC->DATA after 8 bits; DATA->EOP on a byte request with tx_valid low; EOP->IDLE after 3 bits.
REQ-011 SHALL hold the bit divider at 0 in IDLE; in other states it counts 0..CLK_DIV-1 and a bit strobe occurs when it equals CLK_DIV-1.
REQ-012 SHALL register tx_line and tx_oe, and SHALL change them only at the strobe or on the IDLE->SYNC edge; each bit is held exactly CLK_DIV cycles.
REQ-013 SHALL assert tx_oe and drive the first SYNC bit (K) in the cycle after tx_valid is sampled high in IDLE.
REQ-014 SHALL send SYNC as NRZI of byte 0x80 LSB first, starting from J, giving line states K,J,K,J,K,J,K,K.
REQ-015 SHALL apply NRZI to the data: a 0 bit toggles J<->K and a 1 bit holds the previous state.
REQ-016 SHALL pulse tx_ready at the strobe that ends the last SYNC bit and at the strobe that ends the 8th data bit of each byte; the new byte's first bit appears on the following cycle.
REQ-017 SHALL count consecutive 1 bits with a ones counter; the counter includes the final SYNC 1, so it equals 1 on entry to DATA.
REQ-018 SHALL reset the ones counter on every 0 bit, including stuffed bits.
REQ-019 When the ones counter reaches USB_STUFF_BITS_N (6), SHALL insert a stuffed 0 (one toggle) in the next bit slot without consuming a data bit; byte requests slip by one bit time.
REQ-020 SHALL emit a pending stuff bit, when the final data bit completes a run of 6 ones, before starting EOP.
REQ-021 SHALL send EOP as SE0, SE0, J (one bit time each); tx_oe and tx_busy SHALL fall in the cycle after the J bit ends, and the FSM SHALL return to IDLE.
REQ-022 SHALL ignore tx_valid during EOP; a new packet can start at the earliest in the first IDLE cycle.
REQ-023 In IDLE SHALL drive tx_line=J and tx_oe=0.

Reset
REQ-024 On rst SHALL set state=IDLE, divider=0, ones counter=0, bit counter=0, tx_line=J, tx_oe=0, tx_ready=0, tx_busy=0.
REQ-025 rst asserted mid-packet SHALL abort immediately, with no EOP; outputs take their reset values on the next cycle.

Configuration
REQ-026 With macro USB_PHY_TX_ABORT_EN defined, SHALL add input port tx_abort (1 bit).
REQ-027 With USB_PHY_TX_ABORT_EN defined, tx_abort high in SYNC or DATA SHALL cause, from the next bit slot, 7 bit times with no transitions (a forced stuff error), then EOP; tx_ready SHALL stay low after the abort.
REQ-028 Without USB_PHY_TX_ABORT_EN, SHALL have no tx_abort port and no abort logic.

Verification
REQ-029 SHALL verify, with CLK_DIV=4 and a single byte 0xA5 (tx_valid dropped after the tx_ready pulse): tx_line = K,J,K,J,K,J,K,K, K,J,J,K,J,J,K,K, SE0,SE0,J, each bit 4 cycles; tx_oe high for 76 cycles.
REQ-030 SHALL verify that byte 0xFF gives data states K,K,K,K,K,J(stuff),J,J,J, with the next tx_ready 36 cycles after the previous one.
REQ-031 SHALL verify that bytes 0x00,0xFC give a stuffed toggle after the last data bit and before the first SE0.
REQ-032 SHALL verify, for 3 back-to-back bytes, exactly 3 tx_ready pulses 32 cycles apart with no gap bits between bytes.
REQ-033 SHALL verify that rst asserted in the 3rd data bit gives tx_oe=0, tx_line=J, tx_busy=0 on the next cycle, with no SE0 driven.
REQ-034 SHALL verify, with USB_PHY_TX_ABORT_EN defined, that tx_abort during DATA gives 7 constant-state bits, then SE0,SE0,J, with no further tx_ready.
